lvt_write_arbiter: RTL and testbench

LVT_WRITE_ARBITER -- requirements
Module: lvt_write_arbiter

---
 rtl/lvt_write_arbiter_if.sv | 26 ++
 rtl/lvt_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_lvt_write_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lvt_write_arbiter_if.sv
// Requester-side handshake bundle for the LVT write arbiter.
// Master drives requests; slave (the arbiter) returns per-requester grants.
interface lvt_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/lvt_write_arbiter.sv
// Round-robin arbiter folding NUM_REQ write requesters onto the two write
// ports of an LVT register file. Optional macro LVT_ARB_STATS_EN enables
// the saturating same-address conflict counter.
module lvt_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hold,
    lvt_write_arbiter_if.slave req,
    output logic              we0,
    output logic [ADDR_W-1:0] write_addr_0,
    output logic [DATA_W-1:0] write_data_0,
    output logic              we1,
    output logic [ADDR_W-1:0] write_addr_1,
    output logic [DATA_W-1:0] write_data_1,
    output logic [15:0]       conflict_count
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      rr_ptr_d;
    logic               found_a;
    logic               found_b;
    logic [PW-1:0]      a_idx;
    logic [PW-1:0]      b_idx;
    logic [PW-1:0]      last_idx;
    logic [ADDR_W-1:0]  a_addr;
    logic [ADDR_W-1:0]  b_addr;
    logic [DATA_W-1:0]  a_data;
    logic [DATA_W-1:0]  b_data;
    logic [ADDR_W-1:0]  cur_addr;
    logic [NUM_REQ-1:0] ready;
`ifdef LVT_ARB_STATS_EN
    logic [3:0]         conf_events;
`endif

    logic               we0_q;
    logic               we1_q;
    logic [ADDR_W-1:0]  addr0_q;
    logic [ADDR_W-1:0]  addr1_q;
    logic [DATA_W-1:0]  data0_q;
    logic [DATA_W-1:0]  data1_q;

    // Scan from rr_ptr with wrap: first valid is A, next differing address is B.
    always_comb begin
        int j;
        found_a  = 1'b0;
        found_b  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        a_addr   = '0;
        b_addr   = '0;
        a_data   = '0;
        b_data   = '0;
        cur_addr = '0;
        ready    = '0;
`ifdef LVT_ARB_STATS_EN
        conf_events = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cur_addr = req.req_addr[j*ADDR_W +: ADDR_W];
            if (reset_n && !hold && req.req_valid[j]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    a_idx   = PW'(j);
                    a_addr  = cur_addr;
                    a_data  = req.req_data[j*DATA_W +: DATA_W];
                end else if (!found_b) begin
                    if (cur_addr != a_addr) begin
                        found_b = 1'b1;
                        b_idx   = PW'(j);
                        b_addr  = cur_addr;
                        b_data  = req.req_data[j*DATA_W +: DATA_W];
                    end
`ifdef LVT_ARB_STATS_EN
                    else begin
                        conf_events = conf_events + 4'd1;
                    end
`endif
                end
            end
        end
        if (found_a) begin
            ready[a_idx] = 1'b1;
        end
        if (found_b) begin
            ready[b_idx] = 1'b1;
        end
    end

    assign req.req_ready = ready;

    // Pointer advances past the last granted requester, else stays put.
    always_comb begin
        last_idx = found_b ? b_idx : a_idx;
        rr_ptr_d = rr_ptr_q;
        if (found_a) begin
            if (last_idx == PW'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_idx + PW'(1);
            end
        end
    end

    // Register grants onto the write ports; idle ports keep addr/data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we0_q    <= found_a;
            we1_q    <= found_b;
            if (found_a) begin
                addr0_q <= a_addr;
                data0_q <= a_data;
            end
            if (found_b) begin
                addr1_q <= b_addr;
                data1_q <= b_data;
            end
        end
    end

    assign we0          = we0_q;
    assign we1          = we1_q;
    assign write_addr_0 = addr0_q;
    assign write_addr_1 = addr1_q;
    assign write_data_0 = data0_q;
    assign write_data_1 = data1_q;

`ifdef LVT_ARB_STATS_EN
    logic [15:0] cnt_q;
    logic [16:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + 17'(conf_events);

    // Saturating accumulation of same-address conflict events.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    assign conflict_count = cnt_q;
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_lvt_write_arbiter.sv
// Directed bench for lvt_write_arbiter with an expected-output scoreboard.
// Conflict-count expectations follow LVT_ARB_STATS_EN.
module tb_lvt_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef LVT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic          we0;
        logic          we1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [15:0]   cnt;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          hold;
    logic          we0;
    logic          we1;
    logic [AW-1:0] write_addr_0;
    logic [AW-1:0] write_addr_1;
    logic [DW-1:0] write_data_0;
    logic [DW-1:0] write_data_1;
    logic [15:0]   conflict_count;

    lvt_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    lvt_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .hold           (hold),
        .req            (bus.slave),
        .we0            (we0),
        .write_addr_0   (write_addr_0),
        .write_data_0   (write_data_0),
        .we1            (we1),
        .write_addr_1   (write_addr_1),
        .write_data_1   (write_data_1),
        .conflict_count (conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    int            exp_cnt = 0;
    exp_t          sb[$];
    logic [AW-1:0] addr_tb[NR];
    logic [DW-1:0] data_tb[NR];
    logic [AW-1:0] ea0, ea1;
    logic [DW-1:0] ed0, ed1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        addr_tb[i] = a;
        data_tb[i] = d;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("we0", 32'(we0), 32'(e.we0));
            chk("we1", 32'(we1), 32'(e.we1));
            chk("addr0", 32'(write_addr_0), 32'(e.a0));
            chk("addr1", 32'(write_addr_1), 32'(e.a1));
            chk("data0", write_data_0, e.d0);
            chk("data1", write_data_1, e.d1);
            chk("cnt", 32'(conflict_count), 32'(e.cnt));
        end
    endtask

    task automatic push_exp(input logic w0, input logic w1);
        exp_t e;
        e.we0 = w0;
        e.we1 = w1;
        e.a0  = ea0;
        e.a1  = ea1;
        e.d0  = ed0;
        e.d1  = ed1;
        e.cnt = 16'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic step(input logic [NR-1:0] v, input logic h,
                        input logic [NR-1:0] rdy,
                        input logic w0, input int ia,
                        input logic w1, input int ib,
                        input int nconf);
        bus.req_valid = v;
        hold = h;
        #1;
        chk("ready", 32'(bus.req_ready), 32'(rdy));
        if (w0) begin
            ea0 = addr_tb[ia];
            ed0 = data_tb[ia];
        end
        if (w1) begin
            ea1 = addr_tb[ib];
            ed1 = data_tb[ib];
        end
        if (STATS) begin
            exp_cnt = exp_cnt + nconf;
            if (exp_cnt > 65535) exp_cnt = 65535;
        end
        push_exp(w0, w1);
        @(posedge clock);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '1;
        #1;
        chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
        ea0 = '0;
        ea1 = '0;
        ed0 = '0;
        ed1 = '0;
        exp_cnt = 0;
        push_exp(1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_out();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        hold = 1'b0;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        ea0 = '0;
        ea1 = '0;
        ed0 = '0;
        ed1 = '0;
        @(posedge clock);
        #1;
        do_reset();

        for (int i = 0; i < NR; i++) load(i, AW'(i + 1), 32'h1111_0000 + i);
        step(4'b1111, 0, 4'b0011, 1, 0, 1, 1, 0);
        step(4'b1100, 0, 4'b1100, 1, 2, 1, 3, 0);
        step(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);

        load(0, 5'd7, 32'hC0DE_0000);
        load(2, 5'd7, 32'hC0DE_0002);
        step(4'b0101, 0, 4'b0001, 1, 0, 0, 0, 1);
        step(4'b0100, 0, 4'b0100, 1, 2, 0, 0, 0);

        load(3, 5'd9, 32'h9999_0003);
        load(0, 5'd10, 32'hAAAA_0000);
        step(4'b1001, 0, 4'b1001, 1, 3, 1, 0, 0);

        for (int i = 0; i < NR; i++) load(i, AW'(i + 11), 32'h5555_0000 + i);
        step(4'b1111, 0, 4'b0110, 1, 1, 1, 2, 0);
        step(4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b1111, 0, 4'b1001, 1, 3, 1, 0, 0);
        step(4'b1111, 0, 4'b0110, 1, 1, 1, 2, 0);

        do_reset();
        step(4'b1111, 0, 4'b0011, 1, 0, 1, 1, 0);

        for (int i = 0; i < NR; i++) load(i, 5'd5, 32'h7777_0000 + i);
        step(4'b1111, 0, 4'b0100, 1, 2, 0, 0, 3);
        step(4'b1111, 0, 4'b1000, 1, 3, 0, 0, 3);

`ifdef LVT_ARB_STATS_EN
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 21845; n++) begin
            @(posedge clock);
        end
        #1;
        exp_cnt = 65535;
        ea0 = addr_tb[0];
        ed0 = data_tb[0];
        chk("cnt_saturated", 32'(conflict_count), 32'hFFFF);
        step(4'b1111, 0, 4'b0010, 1, 1, 0, 0, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
